logic_arbiter: RTL and testbench
================================

# logic_arbiter

Shares one 16-bit bitwise logic unit between up to four requesters. Round-robin arbitration, per-requester operand capture, single-cycle execution, registered result held until the consumer acknowledges. Sits between the instruction sequencers / DMA helpers and the gate-level 16-bit logic datapath (AND16 and sibling bitwise modules).

## Interface
- N_REQ, 2, number of requesters; legal range 2..4; ID width fixed at 2 bits
- CLK  in  1  clock; all state updates on rising edge
- RST  in  1  reset, asynchronous, active-high
- REQ  in  N_REQ  per-requester request; requester holds REQ, OP, X, Y stable until its GNT
- OP  in  2*N_REQ  per-requester opcode, slice i = OP[2i+1:2i]: 00 AND, 01 OR, 10 XOR, 11 NOT X (Y ignored)
- X  in  16*N_REQ  operand A, slice i = X[16i+15:16i]
- Y  in  16*N_REQ  operand B, same slicing
- GNT  out  N_REQ  one-hot accept pulse, combinational, one cycle
- OUT  out  16  result
- OUT_VALID  out  1  result available
- OUT_ID  out  2  index of requester that owns OUT
- OUT_ACK  in  1  consumer takes result; only meaningful while OUT_VALID

## Operation
- States: IDLE, EXEC, DONE (encoding in package).
- IDLE: GNT = 0 if REQ = 0. Otherwise exactly one GNT bit set, chosen round-robin: search starts at LAST+1 mod N_REQ, first set REQ bit wins. At the edge: capture winner's OP/X/Y and index, LAST <= winner, go EXEC.
- EXEC: logic unit evaluates captured operands; at the edge OUT <= result, OUT_ID <= captured index, go DONE.
- DONE: OUT_VALID = 1; OUT, OUT_ID stable. OUT_ACK = 1 -> IDLE at the edge. OUT_ACK = 0 -> stay.
- GNT is 0 in EXEC and DONE regardless of REQ; new grants only from IDLE.
- REQ dropped before its GNT: no grant, no state change, pointer unchanged.
- OUT_ACK outside DONE: ignored.
- Single requester continuously asserting: served every 3 cycles, no starvation of others (pointer advances past winner).
- NOT X: OUT = ~X, Y value has no effect.
- REQ bits at index >= N_REQ do not exist; no X propagation from unused ID bits (OUT_ID upper bit 0 when N_REQ = 2).

## Timing
- Reset (async assert, sync deassert expected from system): state IDLE, LAST = N_REQ-1 (requester 0 first priority), OUT = 16'h0000, OUT_VALID = 0, OUT_ID = 0, captured operands = 0.
- Request to GNT: 0 cycles (combinational in IDLE).
- GNT edge to OUT_VALID high: 2 edges (EXEC, then DONE).
- OUT_ACK to next possible GNT: 1 cycle (IDLE next cycle).
- Minimum period per operation: 3 cycles with OUT_ACK tied high.
- Reset mid-EXEC or mid-DONE: operation discarded, OUT_VALID drops asynchronously, no GNT reissued; requester must re-request.
- GNT has no path from OUT_ACK (no comb loop from consumer).

## Configuration
- LOGIC_ARB_CNT_EN defined: extra output OP_COUNT out 16, counts completed operations (DONE with OUT_ACK); reset 0; saturates at 16'hFFFF; reset clears.
- Not defined: port and counter absent; all other behaviour identical.

## Structure
- Package logic_arb_pkg: op_e enum (OP_AND, OP_OR, OP_XOR, OP_NOTX), state_e enum (IDLE, EXEC, DONE), WORD_W = 16, ID_W = 2, MAX_REQ = 4.
- Sub-module rr_pick: combinational round-robin picker (REQ, LAST -> one-hot GNT, winner index, any).
- Logic unit built from existing AND16/OR16/NOT16-style gate-level modules plus 4:1 mux inside logic_arbiter; no separate module.

## Test plan
- Reset: assert RST mid-run -> OUT = 0, OUT_VALID = 0, OUT_ID = 0, GNT = 0 immediately; first grant after release goes to requester 0 when REQ = 2'b11.
- Single op: req 1, OP AND, X = 16'hF0F0, Y = 16'h3C3C -> GNT = 2'b10 same cycle, OUT_VALID 2 edges later, OUT = 16'h3030, OUT_ID = 1.
- Op coverage: X = 16'hAAAA, Y = 16'h0FF0 -> OR 16'hAFFA, XOR 16'hA55A, NOT X 16'h5555 (Y = 16'hFFFF gives same).
- Fairness: REQ = 2'b11 held, OUT_ACK = 1 -> grant order 0,1,0,1, one grant every 3 cycles.
- Backpressure: OUT_ACK = 0 for 10 cycles in DONE -> OUT/OUT_ID stable, GNT = 0 despite REQ; ACK -> GNT next cycle.
- LOGIC_ARB_CNT_EN: 5 acked ops -> OP_COUNT = 5; preloaded near 16'hFFFF -> holds at 16'hFFFF.

Source files
------------

// File: rtl/logic_arb_pkg.sv
// Shared types and sizes for the round-robin logic-unit arbiter.
package logic_arb_pkg;

  localparam int WORD_W  = 16;
  localparam int ID_W    = 2;
  localparam int MAX_REQ = 4;

  typedef enum logic [1:0] {
    OP_AND  = 2'b00,
    OP_OR   = 2'b01,
    OP_XOR  = 2'b10,
    OP_NOTX = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    DONE = 2'b10
  } state_e;

endpackage

// File: rtl/logic_arbiter_rr_pick.sv
// Combinational round-robin picker: the first set request after i_last wins.
module rr_pick
  import logic_arb_pkg::*;
#(
  parameter int N_REQ = 2
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [ID_W-1:0]  i_last,
  output logic [N_REQ-1:0] o_gnt,
  output logic [ID_W-1:0]  o_idx,
  output logic             o_any
);

  int w_best_d;
  int w_sel;
  int w_d;

  // Rank each requester by its distance after i_last; the smallest distance wins.
  always_comb begin
    w_best_d = N_REQ;
    w_sel    = 0;
    w_d      = 0;
    for (int i = 0; i < N_REQ; i++) begin
      w_d = (i + 2 * N_REQ - int'(i_last) - 1) % N_REQ;
      if (i_req[i] && (w_d < w_best_d)) begin
        w_best_d = w_d;
        w_sel    = i;
      end
    end
  end

  always_comb begin
    o_any = (w_best_d < N_REQ);
    o_idx = ID_W'(w_sel);
    o_gnt = '0;
    for (int i = 0; i < N_REQ; i++) begin
      o_gnt[i] = o_any && (w_sel == i);
    end
  end

endmodule

// File: rtl/logic_arbiter.sv
// Round-robin sharing of one 16-bit bitwise logic unit between N_REQ requesters.
// Optional op counter output OP_COUNT when LOGIC_ARB_CNT_EN is defined.
module logic_arbiter
  import logic_arb_pkg::*;
#(
  parameter int N_REQ = 2
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [N_REQ-1:0]          REQ,
  input  logic [2*N_REQ-1:0]        OP,
  input  logic [WORD_W*N_REQ-1:0]   X,
  input  logic [WORD_W*N_REQ-1:0]   Y,
  output logic [N_REQ-1:0]          GNT,
  output logic [WORD_W-1:0]         OUT,
  output logic                      OUT_VALID,
  output logic [ID_W-1:0]           OUT_ID,
`ifdef LOGIC_ARB_CNT_EN
  output logic [15:0]               OP_COUNT,
`endif
  input  logic                      OUT_ACK
);

  state_e            r_state, w_state_nxt;
  logic [ID_W-1:0]   r_last, r_idx, r_out_id;
  op_e               r_op;
  logic [WORD_W-1:0] r_x, r_y, r_out;

  logic [N_REQ-1:0]  w_pick_gnt;
  logic [ID_W-1:0]   w_pick_idx;
  logic              w_pick_any;
  logic              w_take;
  logic [1:0]        w_op;
  logic [WORD_W-1:0] w_x, w_y;
  logic [WORD_W-1:0] w_and, w_or, w_xor, w_not, w_res;

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .i_req  (REQ),
    .i_last (r_last),
    .o_gnt  (w_pick_gnt),
    .o_idx  (w_pick_idx),
    .o_any  (w_pick_any)
  );

  // Grants only from IDLE and never while reset is held; no OUT_ACK in this path.
  assign w_take = (r_state == IDLE) && w_pick_any;
  assign GNT    = ((r_state == IDLE) && !RST) ? w_pick_gnt : '0;

  always_comb begin
    w_op = '0;
    w_x  = '0;
    w_y  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_pick_idx == ID_W'(i)) begin
        w_op = OP[2*i +: 2];
        w_x  = X[WORD_W*i +: WORD_W];
        w_y  = Y[WORD_W*i +: WORD_W];
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_pick_any) w_state_nxt = EXEC;
      EXEC:    w_state_nxt = DONE;
      DONE:    if (OUT_ACK) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Gate-level style logic unit on the captured operands.
  assign w_and = r_x & r_y;
  assign w_or  = r_x | r_y;
  assign w_xor = r_x ^ r_y;
  assign w_not = ~r_x;

  always_comb begin
    w_res = w_and;
    case (r_op)
      OP_AND:  w_res = w_and;
      OP_OR:   w_res = w_or;
      OP_XOR:  w_res = w_xor;
      default: w_res = w_not;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_last   <= ID_W'(N_REQ - 1);
      r_idx    <= '0;
      r_op     <= OP_AND;
      r_x      <= '0;
      r_y      <= '0;
      r_out    <= '0;
      r_out_id <= '0;
    end else begin
      if (w_take) begin
        r_last <= w_pick_idx;
        r_idx  <= w_pick_idx;
        r_op   <= op_e'(w_op);
        r_x    <= w_x;
        r_y    <= w_y;
      end
      if (r_state == EXEC) begin
        r_out    <= w_res;
        r_out_id <= r_idx;
      end
    end
  end

  assign OUT       = r_out;
  assign OUT_VALID = (r_state == DONE);
  assign OUT_ID    = r_out_id;

`ifdef LOGIC_ARB_CNT_EN
  logic [15:0] r_cnt;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                                                    r_cnt <= '0;
    else if ((r_state == DONE) && OUT_ACK && (r_cnt != 16'hFFFF)) r_cnt <= r_cnt + 16'd1;
  end

  assign OP_COUNT = r_cnt;
`endif

endmodule

// File: tb/tb_logic_arbiter.sv
// Randomized + directed bench for logic_arbiter against a spec-level reference model.
module tb_logic_arbiter;

  localparam int NR = 4;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  logic [NR-1:0]    d_req;
  logic [2*NR-1:0]  d_op;
  logic [16*NR-1:0] d_x, d_y;
  logic             d_ack;

  logic [NR-1:0]    GNT;
  logic [15:0]      OUT;
  logic             OUT_VALID;
  logic [1:0]       OUT_ID;
`ifdef LOGIC_ARB_CNT_EN
  logic [15:0]      OP_COUNT;
`endif

  logic_arbiter #(.N_REQ(NR)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .REQ       (d_req),
    .OP        (d_op),
    .X         (d_x),
    .Y         (d_y),
    .GNT       (GNT),
    .OUT       (OUT),
    .OUT_VALID (OUT_VALID),
    .OUT_ID    (OUT_ID),
`ifdef LOGIC_ARB_CNT_EN
    .OP_COUNT  (OP_COUNT),
`endif
    .OUT_ACK   (d_ack)
  );

  // staged stimulus, applied at the falling edge by tick
  logic [NR-1:0]    t_req;
  logic [2*NR-1:0]  t_op;
  logic [16*NR-1:0] t_x, t_y;
  logic             t_ack;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // reference model: 0 idle, 1 executing, 2 result held
  int          m_st, m_last, m_cid, m_id, m_cnt, last_w, cyc_n;
  logic [15:0] m_res, m_out;
  int          obs_w[$];
  int          obs_c[$];

  function automatic logic [15:0] ref_op(input logic [1:0] op, input logic [15:0] x, input logic [15:0] y);
    case (op)
      2'd0:    return x & y;
      2'd1:    return x | y;
      2'd2:    return x ^ y;
      default: return ~x;
    endcase
  endfunction

  task automatic model_reset();
    m_st = 0; m_last = NR - 1; m_out = '0; m_id = 0; m_cnt = 0; m_cid = 0; m_res = '0;
  endtask

  task automatic set_req(input int i, input logic [1:0] op, input logic [15:0] x, input logic [15:0] y);
    t_req[i]        = 1'b1;
    t_op[2*i +: 2]  = op;
    t_x[16*i +: 16] = x;
    t_y[16*i +: 16] = y;
  endtask

  task automatic tick();
    int w;
    logic [NR-1:0] eg;
    @(negedge CLK);
    d_req = t_req; d_op = t_op; d_x = t_x; d_y = t_y; d_ack = t_ack;
    cyc_n++;
    #1;
    w = -1;
    eg = '0;
    if (m_st == 0) begin
      for (int k = 1; k <= NR; k++) begin
        int i;
        i = (m_last + k) % NR;
        if (w < 0 && d_req[i]) w = i;
      end
    end
    if (w >= 0) eg[w] = 1'b1;
    chk("gnt", GNT, eg);
    chk("valid", OUT_VALID, m_st == 2);
    if (m_st == 2) begin
      chk("out", OUT, m_out);
      chk("out_id", OUT_ID, m_id);
    end
`ifdef LOGIC_ARB_CNT_EN
    chk("op_count", OP_COUNT, m_cnt);
`endif
    for (int i = 0; i < NR; i++) begin
      if (GNT[i]) begin
        obs_w.push_back(i);
        obs_c.push_back(cyc_n);
      end
    end
    last_w = w;
    case (m_st)
      0: if (w >= 0) begin
        m_res  = ref_op(d_op[2*w +: 2], d_x[16*w +: 16], d_y[16*w +: 16]);
        m_cid  = w;
        m_last = w;
        m_st   = 1;
        t_req[w] = 1'b0;
      end
      1: begin m_out = m_res; m_id = m_cid; m_st = 2; end
      default: if (d_ack) begin
        m_st  = 0;
        m_cnt = (m_cnt == 65535) ? m_cnt : m_cnt + 1;
      end
    endcase
  endtask

  task automatic run_op(input string tag, input int i, input logic [1:0] op,
                        input logic [15:0] x, input logic [15:0] y, input logic [15:0] exp);
    int n;
    set_req(i, op, x, y);
    t_ack = 1'b1;
    n = 0;
    do begin tick(); n++; end while (last_w != i && n < 12);
    if (last_w != i) chk({tag, "_grant_timeout"}, 0, 1);
    tick();
    tick();
    chk(tag, OUT, exp);
    chk({tag, "_id"}, OUT_ID, i);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    t_req = '0; t_op = '0; t_x = '0; t_y = '0; t_ack = 1'b0;
    d_req = '0; d_op = '0; d_x = '0; d_y = '0; d_ack = 1'b0;
    cyc_n = 0; last_w = -1;
    model_reset();

    // reset values, with requests already present
    RST = 1'b1;
    set_req(0, 2'd0, 16'h1111, 16'h0101);
    set_req(1, 2'd1, 16'h2222, 16'h0404);
    d_req = t_req; d_op = t_op; d_x = t_x; d_y = t_y;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_out", OUT, 16'h0000);
    chk("rst_valid", OUT_VALID, 1'b0);
    chk("rst_id", OUT_ID, 2'd0);
    chk("rst_gnt", GNT, '0);
    @(negedge CLK);
    RST = 1'b0;
    d_req = '0;
    t_ack = 1'b1;
    tick();
    chk("first_gnt", GNT, 4'b0001);
    t_req = '0;
    tick();
    tick();

    // single op and op coverage
    run_op("and", 1, 2'd0, 16'hF0F0, 16'h3C3C, 16'h3030);
    run_op("or",  2, 2'd1, 16'hAAAA, 16'h0FF0, 16'hAFFA);
    run_op("xor", 2, 2'd2, 16'hAAAA, 16'h0FF0, 16'hA55A);
    run_op("not", 2, 2'd3, 16'hAAAA, 16'h0FF0, 16'h5555);
    run_op("not_y1", 2, 2'd3, 16'hAAAA, 16'hFFFF, 16'h5555);

    // fairness: two requesters held, consumer always ready
    obs_w.delete(); obs_c.delete();
    t_ack = 1'b1;
    for (int c = 0; c < 12; c++) begin
      set_req(0, 2'd0, 16'h00FF, 16'h0F0F);
      set_req(1, 2'd2, 16'h00FF, 16'h0F0F);
      tick();
    end
    t_req = '0;
    chk("fair_count", obs_w.size(), 4);
    for (int k = 0; k < 4 && k < obs_w.size(); k++) chk("fair_order", obs_w[k], k % 2);
    for (int k = 0; k < 3 && k + 1 < obs_c.size(); k++) chk("fair_period", obs_c[k+1] - obs_c[k], 3);

    // backpressure: result held, no grants while waiting
    t_ack = 1'b0;
    set_req(0, 2'd2, 16'h1234, 16'h00FF);
    tick();
    set_req(1, 2'd1, 16'h5000, 16'h000A);
    tick();
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("bp_gnt", GNT, '0);
      chk("bp_out", OUT, 16'h12CB);
      chk("bp_id", OUT_ID, 2'd0);
    end
    t_ack = 1'b1;
    tick();
    t_ack = 1'b0;
    tick();
    chk("bp_next_gnt", GNT, 4'b0010);
    tick();
    t_ack = 1'b1;
    tick();

    // reset while a result is held
    t_ack = 1'b0;
    set_req(3, 2'd0, 16'hFFFF, 16'h00FF);
    tick();
    tick();
    @(posedge CLK);
    #2;
    chk("pre_rst_valid", OUT_VALID, 1'b1);
    d_req = 4'b0011;
    RST = 1'b1;
    #1;
    chk("mid_rst_valid", OUT_VALID, 1'b0);
    chk("mid_rst_out", OUT, 16'h0000);
    chk("mid_rst_id", OUT_ID, 2'd0);
    chk("mid_rst_gnt", GNT, '0);
    model_reset();
    t_req = '0;
    @(negedge CLK);
    RST = 1'b0;
    d_req = '0;
    set_req(0, 2'd1, 16'h0F00, 16'h00F0);
    set_req(1, 2'd1, 16'h000F, 16'h00F0);
    t_ack = 1'b1;
    tick();
    chk("post_rst_gnt", GNT, 4'b0001);

    // randomized traffic
    for (int c = 0; c < 400; c++) begin
      t_ack = ($urandom_range(2) != 0);
      for (int i = 0; i < NR; i++) begin
        if (!t_req[i] && $urandom_range(3) == 0)
          set_req(i, 2'($urandom_range(3)), 16'($urandom), 16'($urandom));
        else if (t_req[i] && $urandom_range(15) == 0)
          t_req[i] = 1'b0;
      end
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
